// File: rtl/aes_stream_pkg.sv
// Shared types and constants for the AES stream front-end.
// Latency: n/a (types, constants and one elaboration-time helper only).
// Backpressure: n/a.
// Contents: controller state encoding, block geometry, words-per-block helper.
package aes_stream_pkg;

  localparam int BLK_BYTES = 16;
  localparam int BLK_W     = 8 * BLK_BYTES;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    FLUSH = 3'd4
  } state_t;

  // Number of stream words that make up one 128-bit block.
  function automatic int words_per_blk(input int data_w);
    return BLK_W / data_w;
  endfunction

endpackage

// File: rtl/aes_word_packer.sv
// Converts between DATA_W-bit stream words and one 128-bit block buffer.
// Latency: 1 cycle from the last word handshake (unpack) or block load (pack) to the flag change.
// Backpressure: unpack mode refuses words while full; pack mode holds its word until the handshake.
// Ports: i_req is in_valid (unpack) or out_ready (pack); i_word shifts in at the bottom;
//        i_ld loads i_ld_dat and sets full=PACK; o_buf is the whole buffer, top word first;
//        o_full is the registered full flag; o_free is high when the buffer is empty or
//        the last word leaves in this cycle.
module aes_word_packer
  import aes_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit PACK   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_ld,
  input  logic [BLK_W-1:0]  i_ld_dat,
  output logic [BLK_W-1:0]  o_buf,
  output logic              o_full,
  output logic              o_free
);

  localparam int WPB = words_per_blk(DATA_W);
  localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;

  logic [BLK_W-1:0] r_buf;
  logic             r_full;
  logic [CW-1:0]    r_cnt;

  logic [BLK_W-1:0] w_shifted;
  logic             w_step;
  logic             w_last;

  // Both directions shift left by one word: unpack pushes the new word in at the
  // bottom, pack exposes the next word at the top.
  generate
    if (DATA_W == BLK_W) begin : g_whole
      assign w_shifted = i_word;
    end else begin : g_shift
      assign w_shifted = {r_buf[BLK_W-DATA_W-1:0], i_word};
    end
  endgenerate

  assign w_step = i_req && (PACK ? r_full : !r_full);
  assign w_last = (r_cnt == CW'(WPB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf  <= '0;
      r_full <= 1'b0;
      r_cnt  <= '0;
    end else if (i_ld) begin
      r_buf  <= i_ld_dat;
      r_full <= PACK;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_buf <= w_shifted;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      // The final word flips the flag: fills the input side, empties the output side.
      if (w_last) begin
        r_full <= !r_full;
      end
    end
  end

  assign o_buf  = r_buf;
  assign o_full = r_full;
  // Lets the controller start the next block in the same cycle as the last output handshake.
  assign o_free = !r_full || (w_step && w_last);

endmodule

// File: rtl/aes_stream_ctrl.sv
// Stream front-end for the byte-serial AES-128 core: unpack words, load core, drain, repack.
// Latency: first out word CORE_LAT+17 cycles after LOAD cycle 0; block period >= CORE_LAT+18.
// Backpressure: out_ready low holds the result and blocks the next LOAD; in_ready low when input buffer full.
// Ports: clk/rst (sync, active-high); key_in/key_vld (key latch, IDLE only);
//        in_data/in_valid/in_ready (plaintext words); out_data/out_valid/out_ready (ciphertext words);
//        core_rst/core_key/core_din/core_in_vld/core_dout (core side); busy; blk_cnt (completed blocks).
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CORE_LAT = 144,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BLK_W-1:0]  key_in,
  input  logic              key_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              core_rst,
  output logic [7:0]        core_key,
  output logic [7:0]        core_din,
  output logic              core_in_vld,
  input  logic [7:0]        core_dout,
  output logic              busy,
  output logic [CNT_W-1:0]  blk_cnt
);

  // r_cnt counts from LOAD cycle 0 through the end of DRAIN.
  localparam int CW = $clog2(CORE_LAT + BLK_BYTES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [BLK_W-1:0] r_key;
  logic [BLK_W-1:0] r_blk;
  logic [CNT_W-1:0] r_blk_cnt;

  logic [BLK_W-1:0] w_in_buf;
  logic [BLK_W-1:0] w_out_buf;
  logic             w_in_full;
  logic             w_in_free;
  logic             w_out_full;
  logic             w_out_free;
  logic             w_go;
  logic             w_flush;

  assign w_go    = (r_state == IDLE) && w_in_full && w_out_free;
  assign w_flush = (r_state == FLUSH);

  aes_word_packer #(.DATA_W(DATA_W), .PACK(1'b0)) u_in_pack (
    .clk      (clk),
    .rst      (rst),
    .i_req    (in_valid),
    .i_word   (in_data),
    .i_ld     (w_go),
    .i_ld_dat ('0),
    .o_buf    (w_in_buf),
    .o_full   (w_in_full),
    .o_free   (w_in_free)
  );

  aes_word_packer #(.DATA_W(DATA_W), .PACK(1'b1)) u_out_pack (
    .clk      (clk),
    .rst      (rst),
    .i_req    (out_ready),
    .i_word   ('0),
    .i_ld     (w_flush),
    .i_ld_dat (r_blk),
    .o_buf    (w_out_buf),
    .o_full   (w_out_full),
    .o_free   (w_out_free)
  );

  assign in_ready  = w_in_free;
  assign out_valid = w_out_full;
  assign out_data  = w_out_buf[BLK_W-1 -: DATA_W];
  assign blk_cnt   = r_blk_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_go) w_state_nxt = LOAD;
      LOAD:    if (r_cnt == CW'(BLK_BYTES - 1)) w_state_nxt = WAIT;
      WAIT:    if (r_cnt == CW'(CORE_LAT - 1)) w_state_nxt = DRAIN;
      DRAIN:   if (r_cnt == CW'(CORE_LAT + BLK_BYTES - 1)) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: r_blk holds the plaintext during LOAD (shifted out from the top) and
  // collects ciphertext during DRAIN (shifted in at the bottom), so one register serves both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_key     <= '0;
      r_blk     <= '0;
      r_blk_cnt <= '0;
    end else begin
      if ((r_state == IDLE) && key_vld) begin
        r_key <= key_in;
      end
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_go) begin
            r_blk <= w_in_buf;
          end
        end
        LOAD: begin
          r_cnt <= r_cnt + 1'b1;
          r_blk <= {r_blk[BLK_W-9:0], 8'h00};
        end
        WAIT: r_cnt <= r_cnt + 1'b1;
        DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          r_blk <= {r_blk[BLK_W-9:0], core_dout};
        end
        FLUSH: begin
          r_cnt     <= '0;
          r_blk_cnt <= r_blk_cnt + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Outputs. During LOAD r_cnt[3:0] is the byte index; key byte k sits at bits [127-8k -: 8].
  always_comb begin
    core_rst    = 1'b1;
    core_in_vld = 1'b0;
    core_key    = '0;
    core_din    = '0;
    busy        = (r_state != IDLE);
    case (r_state)
      LOAD: begin
        core_rst    = 1'b0;
        core_in_vld = 1'b1;
        core_key    = r_key[{~r_cnt[3:0], 3'b000} +: 8];
        core_din    = r_blk[BLK_W-1 -: 8];
      end
      WAIT, DRAIN: core_rst = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl (DATA_W=32, CORE_LAT=144) with an XOR stand-in core.
// The stand-in core returns plaintext XOR key, byte k appearing CORE_LAT+k cycles after
// the first load byte, so expected ciphertext is computed by hand below.
module tb_aes_stream_ctrl;

  localparam int DW   = 32;
  localparam int LAT  = 144;
  localparam int CNTW = 16;
  localparam int WPB  = 128 / DW;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] P3 = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] C1 = 128'h00102030405060708090a0b0c0d0e0f0; // P1 ^ K1
  localparam logic [127:0] C2 = 128'h012247648daecbe8f6d5b0937a593c1f; // P2 ^ K1
  localparam logic [127:0] C3 = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0; // P3 ^ K1
  localparam logic [127:0] C4 = 128'hffeeddccbbaa99887766554433221100; // P1 ^ K2

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [127:0]    key_in;
  logic            key_vld;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            core_rst;
  logic [7:0]      core_key;
  logic [7:0]      core_din;
  logic            core_in_vld;
  logic [7:0]      core_dout;
  logic            busy;
  logic [CNTW-1:0] blk_cnt;

  always #5 clk = ~clk;

  aes_stream_ctrl #(.DATA_W(DW), .CORE_LAT(LAT), .CNT_W(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_vld     (key_vld),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .core_rst    (core_rst),
    .core_key    (core_key),
    .core_din    (core_din),
    .core_in_vld (core_in_vld),
    .core_dout   (core_dout),
    .busy        (busy),
    .blk_cnt     (blk_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_cnt = 0;
  logic [7:0]    ct [16];
  logic [DW-1:0] out_q [$];
  int            out_t [$];
  int            load_t [$];
  logic [DW-1:0] tx_q [$];

  // Stand-in core: m_cnt is the cycle index since the core left reset (0 = first load byte).
  always @(posedge clk) begin
    if (core_rst) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (core_in_vld && m_cnt < 16) ct[4'(m_cnt)] <= core_din ^ core_key;
    end
  end
  assign core_dout = (m_cnt >= LAT && m_cnt < LAT + 16) ? ct[4'(m_cnt - LAT)] : 8'h5a;

  // Log LOAD cycle 0 and every output handshake with the cycle number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_in_vld && m_cnt == 0) load_t.push_back(cyc);
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      out_t.push_back(cyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string pre);
    chk({pre, "_in_ready"}, in_ready, 1);
    chk({pre, "_out_valid"}, out_valid, 0);
    chk({pre, "_out_data"}, out_data, 0);
    chk({pre, "_core_rst"}, core_rst, 1);
    chk({pre, "_core_in_vld"}, core_in_vld, 0);
    chk({pre, "_core_key"}, core_key, 0);
    chk({pre, "_core_din"}, core_din, 0);
    chk({pre, "_busy"}, busy, 0);
    chk({pre, "_blk_cnt"}, blk_cnt, 0);
  endtask

  task automatic push_blk(input logic [127:0] b);
    for (int k = 0; k < WPB; k++) tx_q.push_back(b[127 - DW*k -: DW]);
  endtask

  // Streams tx_q with in_valid held high; returns in the cycle after the last acceptance.
  task automatic send_all(input string tag);
    int   i = 0;
    int   c = 0;
    logic ok;
    while (i < tx_q.size() && c < 3000) begin
      in_data  = tx_q[i];
      in_valid = 1'b1;
      ok       = in_ready;
      tick;
      if (ok) i++;
      c++;
    end
    in_valid = 1'b0;
    chk(tag, i, tx_q.size());
    tx_q.delete();
  endtask

  task automatic wait_outs(input string tag, input int n);
    int c = 0;
    while (out_q.size() < n && c < 2000) begin
      tick;
      c++;
    end
    chk(tag, out_q.size(), n);
  endtask

  task automatic exp_blk(input string tag, input int base, input logic [127:0] e);
    for (int k = 0; k < WPB; k++)
      chk($sformatf("%s_w%0d", tag, k), out_q[base + k], e[127 - DW*k -: DW]);
  endtask

  initial begin
    logic [DW-1:0] w0;
    logic          stable;
    int            c;

    in_valid  = 1'b0;
    in_data   = '0;
    key_in    = '0;
    key_vld   = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    repeat (3) tick;
    chk_reset("reset");
    rst = 1'b0;
    tick;

    // Single block, free-running output.
    key_in  = K1;
    key_vld = 1'b1;
    tick;
    key_vld = 1'b0;
    push_blk(P1);
    send_all("t1_send");
    wait_outs("t1_outs", 4);
    exp_blk("t1", 0, C1);
    chk("t1_latency", out_t[0] - load_t[0], LAT + 17);
    chk("t1_burst", out_t[3] - out_t[0], WPB - 1);
    chk("t1_blk_cnt", blk_cnt, 1);

    // Output stalled with a second block queued; key_vld outside IDLE must be ignored.
    out_ready = 1'b0;
    push_blk(P2);
    push_blk(P3);
    send_all("bp_send");
    repeat (30) tick;
    chk("bp_busy_in_wait", busy, 1);
    key_in  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    key_vld = 1'b1;
    tick;
    key_vld = 1'b0;
    c = 0;
    while (!out_valid && c < 1000) begin
      tick;
      c++;
    end
    chk("bp_out_valid", out_valid, 1);
    w0     = out_data;
    stable = 1'b1;
    repeat (500) begin
      tick;
      if (out_data !== w0 || !out_valid) stable = 1'b0;
    end
    chk("bp_hold_stable", stable, 1);
    chk("bp_hold_word", w0, 32'h01224764);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_idle", busy, 0);
    chk("bp_no_load", load_t.size(), 2);
    out_ready = 1'b1;
    wait_outs("bp_outs", 12);
    exp_blk("bp_b", 4, C2);
    exp_blk("bp_c", 8, C3);
    chk("bp_load_after_last_hs", load_t[2] - out_t[7], 1);
    chk("bp_blk_cnt", blk_cnt, 3);

    // Back-to-back: LOAD-to-LOAD is CORE_LAT+17 to the first out word, plus WPB words to drain.
    push_blk(P1);
    push_blk(P2);
    push_blk(P3);
    send_all("b2b_send");
    wait_outs("b2b_outs", 24);
    exp_blk("b2b_0", 12, C1);
    exp_blk("b2b_1", 16, C2);
    exp_blk("b2b_2", 20, C3);
    chk("b2b_gap01", load_t[4] - load_t[3], LAT + 17 + WPB);
    chk("b2b_gap12", load_t[5] - load_t[4], LAT + 17 + WPB);
    chk("b2b_blk_cnt", blk_cnt, 6);

    // Reset during WAIT with a partial second block queued, then a new key in the LOAD-start cycle.
    push_blk(P1);
    tx_q.push_back(32'h0badf00d);
    tx_q.push_back(32'h12345678);
    send_all("mid_send");
    repeat (40) tick;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick;
    chk_reset("mid_rst");
    rst = 1'b0;
    tick;
    push_blk(P1);
    send_all("post_send");
    key_in  = K2;
    key_vld = 1'b1;
    tick;
    key_vld = 1'b0;
    wait_outs("post_outs", 28);
    exp_blk("post", 24, C4);
    chk("post_blk_cnt", blk_cnt, 1);
    repeat (20) tick;
    chk("post_no_extra", out_q.size(), 28);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
